serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 37 +++
 rtl/serial_subtractor_full_subtractor.sv | 28 ++
 rtl/serial_subtractor.sv | 117 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared definitions for the bit-serial subtractor.
//            - FSM state encoding (IDLE / RUN / DONE).
//            - Bit-counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  // FSM state encoding, 2 bits wide
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2 for small positive values (operand widths are at most 32).
  // The loop stops at 30 so that the shifted probe never turns negative.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Width of the bit counter.  It only has to reach WIDTH-1, but sizing it
  // for WIDTH+1 values keeps the WIDTH=2^n cases comfortably in range.
  function automatic int cnt_width(input int width);
    return clog2(width + 1);
  endfunction

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Purpose  : Single-bit combinational full subtractor, x - y - bi.
// Ports    : x  (in)  minuend bit
//            y  (in)  subtrahend bit
//            bi (in)  borrow in
//            d  (out) difference bit
//            bo (out) borrow out
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic w_xy;

  assign w_xy = x ^ y;
  assign d    = w_xy ^ bi;
  // Borrow when y exceeds x outright, or when x==y and a borrow is pending.
  assign bo   = (~x & y) | (~w_xy & bi);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned subtractor, LSB first, one bit per clock.
//            diff = (a - b - bin) mod 2^WIDTH, bout = (a < b + bin).
// Ports    : clk   (in)  rising-edge clock
//            rst_n (in)  asynchronous active-low reset
//            start (in)  request, honoured in IDLE or DONE
//            a     (in)  minuend, WIDTH bits
//            b     (in)  subtrahend, WIDTH bits
//            bin   (in)  borrow in
//            busy  (out) subtraction in progress
//            done  (out) one-cycle pulse, diff/bout valid
//            diff  (out) result, held until next accept or reset
//            bout  (out) borrow out, held like diff
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_bi;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic w_d;
  logic w_bo;
  logic w_accept;

  // The one shared arithmetic cell; it always looks at the current LSBs.
  full_subtractor u_cell (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .bi (r_bi),
    .d  (w_d),
    .bo (w_bo)
  );

  // A new request is taken in IDLE and also in DONE, which gives
  // back-to-back operation with no idle bubble.
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_bi    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_bi    <= bin;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          // Difference bits enter at the MSB; after WIDTH shifts the first
          // bit computed has walked down to bit 0.
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_bi   <= w_bo;
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_bout  <= w_bo;
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register, so busy and done
  // can never be high together.
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule : serial_subtractor
`default_nettype wire
